scoot_arena: RTL and testbench

SCOOT_ARENA -- requirements
Module: scoot_arena

---
 rtl/scoot_arena.sv | 164 ++++++++++++++++
 tb/tb_scoot_arena.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scoot_arena.sv
// rtl/scoot_arena.sv - toroidal food-grid arena stepping a bot through a fixed number of moves
module scoot_arena #(
  parameter int WIDTH = 10,
  parameter int HEIGHT = 10,
  parameter int NUM_STEPS = 100,
  parameter int STEP_CYCLES = 8,
  parameter logic [HEIGHT-1:0] INIT_COL = 10'b0010101001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mUp,
  input  logic       mRight,
  input  logic       mDown,
  input  logic       mLeft,
  output logic       lUp,
  output logic       lRight,
  output logic       lDown,
  output logic       lLeft,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [6:0] pickups,
  output logic [6:0] steps,
  output logic       picked,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_SENSE, S_WAIT, S_MOVE, S_DONE} state_t;

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [6:0] STEPS_LAST = 7'(NUM_STEPS);
  localparam logic [3:0] X0 = 4'(WIDTH / 2);
  localparam logic [3:0] Y0 = 4'(HEIGHT / 2);
  localparam logic [3:0] XMAX = 4'(WIDTH - 1);
  localparam logic [3:0] YMAX = 4'(HEIGHT - 1);

  state_t                        state_q, state_d;
  logic [WIDTH-1:0][HEIGHT-1:0]  grid_q, grid_d;
  logic [3:0]                    x_q, x_d, y_q, y_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [6:0]                    pickups_q, pickups_d, steps_q, steps_d;
  logic                          lup_q, lup_d, lright_q, lright_d;
  logic                          ldown_q, ldown_d, lleft_q, lleft_d;
  logic                          picked_q, picked_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]                    x_inc, x_dec, y_inc, y_dec;

  always_comb begin
    x_inc = (x_q == XMAX) ? 4'd0 : x_q + 4'd1;
    x_dec = (x_q == 4'd0) ? XMAX : x_q - 4'd1;
    y_inc = (y_q == YMAX) ? 4'd0 : y_q + 4'd1;
    y_dec = (y_q == 4'd0) ? YMAX : y_q - 4'd1;

    state_d   = state_q;
    grid_d    = grid_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    pickups_d = pickups_q;
    steps_d   = steps_q;
    lup_d     = lup_q;
    lright_d  = lright_q;
    ldown_d   = ldown_q;
    lleft_d   = lleft_q;
    picked_d  = 1'b0;
    done_d    = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          grid_d    = {WIDTH{INIT_COL}};
          x_d       = X0;
          y_d       = Y0;
          pickups_d = 7'd0;
          steps_d   = 7'd0;
          done_d    = 1'b0;
          state_d   = S_SENSE;
        end
      end
      S_SENSE: begin
        if (grid_q[x_q][y_q]) begin
          grid_d[x_q][y_q] = 1'b0;
          pickups_d        = pickups_q + 7'd1;
          picked_d         = 1'b1;
        end
        // Neighbours are never the current cell (both dimensions >= 2), so pre-clear grid is fine.
        lup_d    = grid_q[x_q][y_inc];
        ldown_d  = grid_q[x_q][y_dec];
        lright_d = grid_q[x_inc][y_q];
        lleft_d  = grid_q[x_dec][y_q];
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_MOVE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_MOVE: begin
        if (mRight && !mLeft)      x_d = x_inc;
        else if (mLeft && !mRight) x_d = x_dec;
        if (mUp && !mDown)         y_d = y_inc;
        else if (mDown && !mUp)    y_d = y_dec;
        steps_d = steps_q + 7'd1;
        if (steps_d == STEPS_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SENSE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SENSE) || (state_d == S_WAIT) || (state_d == S_MOVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grid_q    <= {WIDTH{INIT_COL}};
      x_q       <= X0;
      y_q       <= Y0;
      cnt_q     <= '0;
      pickups_q <= 7'd0;
      steps_q   <= 7'd0;
      lup_q     <= 1'b0;
      lright_q  <= 1'b0;
      ldown_q   <= 1'b0;
      lleft_q   <= 1'b0;
      picked_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      pickups_q <= pickups_d;
      steps_q   <= steps_d;
      lup_q     <= lup_d;
      lright_q  <= lright_d;
      ldown_q   <= ldown_d;
      lleft_q   <= lleft_d;
      picked_q  <= picked_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign lUp     = lup_q;
  assign lRight  = lright_q;
  assign lDown   = ldown_q;
  assign lLeft   = lleft_q;
  assign pos_x   = x_q;
  assign pos_y   = y_q;
  assign pickups = pickups_q;
  assign steps   = steps_q;
  assign picked  = picked_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_scoot_arena.sv
// tb/tb_scoot_arena.sv - scoreboard bench for scoot_arena against a grid-walk reference model
module tb_scoot_arena;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int NS = 100;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst, start, mUp, mRight, mDown, mLeft;
  logic lUp, lRight, lDown, lLeft, picked, busy, done;
  logic [3:0] pos_x, pos_y;
  logic [6:0] pickups, steps;

  scoot_arena dut (
    .clk(clk), .rst(rst), .start(start),
    .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
    .lUp(lUp), .lRight(lRight), .lDown(lDown), .lLeft(lLeft),
    .pos_x(pos_x), .pos_y(pos_y), .pickups(pickups), .steps(steps),
    .picked(picked), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int pk; int st;
    bit lu; bit lr; bit ld; bit ll;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int prev_steps = 0;

  bit grid[W][H];
  logic [H-1:0] init_col = 10'b0010101001;
  int mx, my, mpick, mstep;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reload();
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++)
        grid[i][j] = init_col[j];
    mx = W / 2; my = H / 2; mpick = 0; mstep = 0;
  endtask

  // m = {up, right, down, left}
  task automatic model_step(input logic [3:0] m);
    exp_t e;
    if (grid[mx][my]) begin
      grid[mx][my] = 1'b0;
      mpick++;
    end
    e.lu = grid[mx][(my + 1) % H];
    e.ld = grid[mx][(my + H - 1) % H];
    e.lr = grid[(mx + 1) % W][my];
    e.ll = grid[(mx + W - 1) % W][my];
    mx = (mx + W + int'(m[2]) - int'(m[0])) % W;
    my = (my + H + int'(m[3]) - int'(m[1])) % H;
    mstep++;
    e.x = mx; e.y = my; e.pk = mpick; e.st = mstep;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (picked) pulse_cnt++;
    if (int'(steps) != prev_steps) begin
      if (steps != 7'd0) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL step_unexpected actual=steps%0d required=no_step", steps);
        end else begin
          e = sb.pop_front();
          total++;
          if (int'(pos_x) != e.x || int'(pos_y) != e.y || int'(pickups) != e.pk ||
              int'(steps) != e.st || lUp != e.lu || lRight != e.lr || lDown != e.ld || lLeft != e.ll) begin
            bad++;
            $display("FAIL step_report actual=x%0d y%0d pk%0d st%0d l%b%b%b%b required=x%0d y%0d pk%0d st%0d l%b%b%b%b",
                     pos_x, pos_y, pickups, steps, lUp, lRight, lDown, lLeft,
                     e.x, e.y, e.pk, e.st, e.lu, e.lr, e.ld, e.ll);
          end
        end
      end
      prev_steps = int'(steps);
    end
  end

  task automatic run(input int rnd, input logic [3:0] fixed, input int abort_step, input bit poke_start);
    logic [3:0] m;
    model_reload();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulse_cnt = 0;
    for (int k = 0; k < NS; k++) begin
      m = (rnd != 0) ? 4'($urandom) : fixed;
      {mUp, mRight, mDown, mLeft} = m;
      model_step(m);
      if (poke_start && k == 50) start = 1'b1;
      for (int c = 0; c < SC + 2; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (k == 0 && c == 0) begin
          chk("first_sense_pickups", int'(pickups), 1);
          chk("first_sense_picked", int'(picked), 1);
        end
        if (k == 10 && c == 3) chk("busy_mid_run", int'(busy), 1);
        if (k == abort_step && c == 2) begin
          rst = 1'b1; #1;
          chk("abort_pos_x", int'(pos_x), 5);
          chk("abort_pos_y", int'(pos_y), 5);
          chk("abort_pickups", int'(pickups), 0);
          chk("abort_steps", int'(steps), 0);
          chk("abort_sensors", int'({lUp, lRight, lDown, lLeft}), 0);
          chk("abort_flags", int'({picked, busy, done}), 0);
          sb.delete();
          {mUp, mRight, mDown, mLeft} = 4'b0;
          @(negedge clk); rst = 1'b0;
          return;
        end
        if (k == NS - 1 && c == SC) chk("done_not_early", int'(done), 0);
      end
    end
    chk("done_on_time", int'(done), 1);
    chk("busy_after_run", int'(busy), 0);
    chk("final_pickups", int'(pickups), mpick);
    chk("picked_pulses", pulse_cnt, mpick);
    {mUp, mRight, mDown, mLeft} = 4'b0;
    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    {mUp, mRight, mDown, mLeft} = 4'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_pos_x", int'(pos_x), 5);
    chk("reset_pos_y", int'(pos_y), 5);
    chk("reset_counts", int'({pickups, steps}), 0);
    chk("reset_outputs", int'({lUp, lRight, lDown, lLeft, picked, busy, done}), 0);

    run(0, 4'b0000, -1, 1'b1);
    chk("idle_motors_pickups", int'(pickups), 1);
    run(0, 4'b0100, -1, 1'b0);
    chk("right_run_pickups", int'(pickups), 10);
    chk("right_run_y", int'(pos_y), 5);
    run(0, 4'b1000, -1, 1'b0);
    chk("up_run_y", int'(pos_y), 5);
    run(0, 4'b0001, -1, 1'b0);
    run(0, 4'b1111, -1, 1'b0);
    chk("opposing_pos", int'({pos_x, pos_y}), 8'h55);
    chk("opposing_steps", int'(steps), NS);
    run(1, 4'b0000, 37, 1'b0);
    run(1, 4'b0000, -1, 1'b0);
    run(1, 4'b0000, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
